// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM state encoding,
// parity_mode encodings and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    // ones_odd is the XOR-reduction of the data word.
    function automatic logic parity_bit(
        input logic [1:0] mode,
        input logic       ones_odd
    );
        case (mode)
            PAR_ODD:  parity_bit = ~ones_odd;
            PAR_EVEN: parity_bit = ones_odd;
            default:  parity_bit = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: tick marks the last clk of each bit period.
// Ports: clk, reset (async, high), clear (hold at 0), div, tick.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // div = 0 is treated as div = 1.
    assign last = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick = !clear && (cnt == last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity, 1/2 stops.
// Ports: clk, reset, div, parity_mode, stop2, tx_data/tx_valid/tx_ready,
// txd, busy, frame_done. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_core: illegal parameter values");
    end

    uart_state_t       state;
    logic [DIV_W-1:0]  div_q;
    logic [1:0]        pm_q;
    logic              stop2_q;
    logic              par_q;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              tick;
    logic              start;
    logic [DATA_W-1:0] word;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    assign tx_ready = !reset && (count != FULL);
    assign push     = tx_valid && tx_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign start    = pop;
    assign word     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end
`else
    assign tx_ready = !reset && (state == IDLE);
    assign start    = tx_valid && tx_ready;
    assign word     = tx_data;
`endif

    assign busy = (state != IDLE);

    // Counter is held clear in IDLE so the start bit gets a full period.
    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            txd        <= 1'b1;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            div_q      <= '0;
            pm_q       <= PAR_NONE;
            stop2_q    <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= START;
                        txd     <= 1'b0;
                        shreg   <= word;
                        div_q   <= div;
                        pm_q    <= parity_mode;
                        stop2_q <= stop2;
                        par_q   <= parity_bit(parity_mode, ^word);
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        txd   <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (pm_q != PAR_NONE) begin
                                state <= PARITY;
                                txd   <= par_q;
                            end else begin
                                state <= STOP1;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP1;
                        txd   <= 1'b1;
                    end
                end
                STOP1: begin
                    if (tick) begin
                        if (stop2_q) begin
                            state <= STOP2;
                        end else begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (tick) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized bench for uart_tx_core: frames are decoded from txd and
// compared with bit sequences built from the frame format rules.
module tb_uart_tx_core;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [DIV_W-1:0]  div;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              txd;
    logic              busy;
    logic              frame_done;

    uart_tx_core #(
        .DATA_W     (DATA_W),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .div         (div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .txd         (txd),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int d;
        int pm;
        int s2;
        int hs;
        bit chk_lat;
    } frame_t;

    frame_t exp_q[$];
    int     n_chk = 0;
    int     n_pass = 0;
    int     cyc = 0;
    int     fd_count = 0;
    int     frames_seen = 0;
    int     last_done_cyc = 0;
    int     last_start_cyc = 0;
    bit     mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done === 1'b1) fd_count <= fd_count + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Monitor: reference bit list per frame, each bit must hold d cycles.
    initial begin : monitor
        frame_t f;
        int     bits[$];
        int     d, match, ones, fd_in;
        forever begin
            @(negedge clk);
            if (mon_en && reset === 1'b0 && txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_start", 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    last_start_cyc = cyc;
                    if (f.chk_lat) check("start_latency", cyc - f.hs, LAT);
                    d = (f.d < 1) ? 1 : f.d;
                    bits = {};
                    ones = 0;
                    bits.push_back(0);
                    for (int i = 0; i < DATA_W; i++) begin
                        bits.push_back((f.data >> i) & 1);
                        ones += (f.data >> i) & 1;
                    end
                    if (f.pm == 1) bits.push_back((ones % 2 == 0) ? 1 : 0);
                    else if (f.pm == 2) bits.push_back(ones % 2);
                    else if (f.pm == 3) bits.push_back(1);
                    bits.push_back(1);
                    if (f.s2 != 0) bits.push_back(1);
                    fd_in = 0;
                    foreach (bits[i]) begin
                        match = 0;
                        for (int c = 0; c < d; c++) begin
                            if (i != 0 || c != 0) @(negedge clk);
                            if (txd === 1'(bits[i])) match++;
                            if (frame_done === 1'b1) fd_in++;
                        end
                        check($sformatf("bit%0d_of_%02h", i, f.data),
                              match, d);
                    end
                    check("early_frame_done", fd_in, 0);
                    @(negedge clk);
                    check("frame_done", int'(frame_done), 1);
                    check("busy_at_end", int'(busy), 0);
                    check("txd_at_end", int'(txd), 1);
                    last_done_cyc = cyc;
                    frames_seen++;
                end
            end
        end
    end

    task automatic push(input int data, input int d, input int pm,
                        input int s2, input bit chk);
        frame_t f;
        int     k;
        tx_data     = DATA_W'(data);
        div         = DIV_W'(d);
        parity_mode = 2'(pm);
        stop2       = 1'(s2);
        tx_valid    = 1'b1;
        k = 0;
        while (tx_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            check("ready_timeout", 0, 1);
            tx_valid = 1'b0;
            return;
        end
        f.data = data & 8'hFF;
        f.d = d;
        f.pm = pm;
        f.s2 = s2;
        f.hs = cyc + 1;
        f.chk_lat = chk;
        exp_q.push_back(f);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (frames_seen < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("frames_seen", frames_seen, n);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, done1, fd0;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        div = DIV_W'(4);
        parity_mode = 2'b00;
        stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", int'(txd), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(tx_ready), 0);
        check("rst_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(tx_ready), 1);

        push(8'hA5, 4, 0, 0, 1'b1);
        wait_frames(1);
        push(8'h00, 1, 1, 1, 1'b1);
        wait_frames(2);
        push(8'hFF, 0, 2, 0, 1'b1);
        wait_frames(3);
        n = 3;

        repeat (12) begin
            push(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 1'b1);
            n++;
            wait_frames(n);
        end

        push(8'h11, 3, 0, 0, 1'b1);
        push(8'h22, 3, 1, 0, 1'b0);
`ifndef UART_TX_FIFO_EN
        repeat (5) @(negedge clk);
        div = DIV_W'(9);
        parity_mode = 2'b11;
        stop2 = 1'b1;
`endif
        wait_frames(n + 1);
        done1 = last_done_cyc;
        wait_frames(n + 2);
        n += 2;
        check("b2b_gap", last_start_cyc - done1, 1);

        mon_en = 1'b0;
        push(8'hA5, 4, 0, 0, 1'b0);
        exp_q.delete();
        repeat (17 + LAT) @(negedge clk);
        check("pre_reset_bit3", int'(txd), 0);
        #1 reset = 1'b1;
        #1;
        check("async_rst_txd", int'(txd), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ready", int'(tx_ready), 0);
        fd0 = fd_count;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (45) @(negedge clk);
        check("no_frame_done_after_abort", fd_count - fd0, 0);
        check("idle_after_abort", int'(txd), 1);
        mon_en = 1'b1;
        push(8'hC3, 2, 2, 1, 1'b1);
        n++;
        wait_frames(n);

`ifdef UART_TX_FIFO_EN
        for (int i = 0; i < 5; i++) begin
            push(8'h30 + i, 8, 0, 0, (i == 0));
        end
        tx_data = 8'hEE;
        tx_valid = 1'b1;
        check("fifo_full_ready", int'(tx_ready), 0);
        tx_valid = 1'b0;
        n += 5;
        wait_frames(n);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, meaning baud divisor width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning FIFO entries (power of 2, >=2); only used with UART_TX_FIFO_EN.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port div  input  DIV_W  clocks per bit.
REQ-007 SHALL have port parity_mode  input  2  00 none, 01 odd, 10 even, 11 mark (always 1).
REQ-008 SHALL have port stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 SHALL have port tx_data  input  DATA_W  word to send.
REQ-010 SHALL have port tx_valid  input  1  tx_data valid.
REQ-011 SHALL have port tx_ready  output  1  block accepts word this cycle.
REQ-012 SHALL have port txd  output  1  serial line, idle high.
REQ-013 SHALL have port busy  output  1  frame in progress (state != IDLE).
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at end of final stop bit.

Function
REQ-015 SHALL transfer a word only on the clk edge where tx_valid and tx_ready are both 1; tx_data is ignored otherwise.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2; IDLE->START on word start, START->DATA, DATA->DATA until DATA_W bits sent, DATA->PARITY if parity_mode != 00 else STOP1, PARITY->STOP1, STOP1->STOP2 if latched stop2 else IDLE, STOP2->IDLE.
REQ-017 SHALL latch div, parity_mode, stop2 and the data word at frame start; changes mid-frame have no effect on the current frame.
REQ-018 SHALL hold each bit on txd for exactly max(div,1) clk cycles; div = 0 behaves as div = 1.
REQ-019 SHALL clear the baud counter at frame start so the start bit lasts exactly max(div,1) cycles; counter does not run in IDLE.
REQ-020 SHALL drive start bit 0, data LSB first, parity bit, stop bits 1; txd = 1 in IDLE.
REQ-021 SHALL compute parity over latched data: odd -> total ones in data+parity odd; even -> even; mark -> 1.
REQ-022 SHALL drive txd low on the clk edge following word start (one-cycle latency).
REQ-023 SHALL pulse frame_done for one cycle, coincident with the STOP->IDLE transition.
REQ-024 Without FIFO, tx_ready SHALL equal (state == IDLE); back-to-back frames therefore have exactly one idle-high clk between final stop bit and next start bit.

Reset
REQ-025 On reset SHALL immediately force state IDLE, txd = 1, busy = 0, frame_done = 0, baud and bit counters 0, FIFO empty; a frame in progress is abandoned, not completed.
REQ-026 tx_ready SHALL be 0 while reset is asserted and follow REQ-024/REQ-029 from the first clk edge after release.

Configuration
REQ-027 SHALL use macro UART_TX_FIFO_EN to compile in a FIFO_DEPTH-entry transmit FIFO.
REQ-028 Without UART_TX_FIFO_EN, behaviour SHALL be exactly REQ-024.
REQ-029 With UART_TX_FIFO_EN, tx_ready SHALL equal !fifo_full, independent of state; push when full is impossible.
REQ-030 With UART_TX_FIFO_EN, the FSM SHALL pop one word in IDLE when FIFO non-empty; first word reaches txd start bit 2 clk after handshake; simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo FIFO_DEPTH.

Structure
REQ-031 SHALL place state enum, parity_mode encodings (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK) in shared package uart_pkg.
REQ-032 SHALL implement the baud counter as sub-module uart_baud_tick (inputs clk, reset, clear, div; output tick).

Verification
REQ-033 div=4, 8N1, send 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1 each 4 cycles, frame_done once at cycle 40 after start bit.
REQ-034 div=1, odd parity, stop2=1, send 0x00 -> parity bit 1, two stop bits, 12 bit-cycles total.
REQ-035 div=0, even parity, send 0xFF -> each bit 1 cycle, parity 0.
REQ-036 No FIFO, tx_valid held, words 0x11 then 0x22 -> exactly one idle-high clk between frames; change div mid-frame -> current frame unaffected.
REQ-037 UART_TX_FIFO_EN, FIFO_DEPTH=4, div=8: push 5 words back-to-back -> tx_ready drops after 5th accept attempt fails until first pop; all 5 transmitted in order.
REQ-038 Assert reset mid-DATA bit 3 -> txd = 1, busy = 0 asynchronously; no frame_done; next frame after release is correct.
